// File: rtl/snake_pkg.sv
// Shared types for the snake game controller: direction and state encodings,
// coordinate types, playfield defaults and direction helpers.
package snake_pkg;

    localparam int COORD_W         = 10;
    localparam int FIELD_W_DEF     = 38;
    localparam int FIELD_H_DEF     = 18;
    localparam int MOVE_FRAMES_DEF = 8;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [COORD_W:0] scoord_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_MOVE  = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    function automatic scoord_t delta_x(dir_t d);
        case (d)
            DIR_RIGHT: delta_x = scoord_t'(1);
            DIR_LEFT:  delta_x = scoord_t'(-1);
            default:   delta_x = scoord_t'(0);
        endcase
    endfunction

    function automatic scoord_t delta_y(dir_t d);
        case (d)
            DIR_DOWN: delta_y = scoord_t'(1);
            DIR_UP:   delta_y = scoord_t'(-1);
            default:  delta_y = scoord_t'(0);
        endcase
    endfunction

    // Opposite directions differ only in the upper encoding bit.
    function automatic logic is_opposite(dir_t a, dir_t b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_if.sv
// Segment read port used by the frame/grid renderer to walk the snake body.
interface snake_if #(
    parameter int IDX_W = 4
);
    logic [IDX_W-1:0] seg_idx;
    logic [9:0]       seg_x;
    logic [9:0]       seg_y;
    logic             seg_valid;

    modport master (output seg_idx, input seg_x, seg_y, seg_valid);
    modport slave  (input seg_idx, output seg_x, seg_y, seg_valid);
endinterface

// File: rtl/snake_tick_gen.sv
// Step tick generator: vsync rising-edge detect plus a frame counter that
// fires once every MOVE_FRAMES enabled edges.
module snake_tick_gen #(
    parameter int MOVE_FRAMES = 8
) (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOVE_FRAMES - 1);

    logic             vsync_p1;
    logic [CNT_W-1:0] frame_cnt;
    logic             rise;

    assign rise = vsync_in & ~vsync_p1;
    assign tick = en & rise & (frame_cnt == LAST);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_p1  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_p1 <= vsync_in;
            if (clr) begin
                frame_cnt <= '0;
            end else if (en && rise) begin
                frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game sequencer: steps the snake on frame ticks, steers from the
// buttons, detects wall/self/food hits and holds the body in a register file.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int MOVE_FRAMES = MOVE_FRAMES_DEF,
    parameter int MAX_LEN     = 16,
    parameter int INIT_LEN    = 3,
    parameter int FIELD_W     = FIELD_W_DEF,
    parameter int FIELD_H     = FIELD_H_DEF,
    localparam int LW         = $clog2(MAX_LEN)
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_right,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic [9:0]  field_x_min,
    input  logic [9:0]  field_y_min,
    input  logic [9:0]  food_x,
    input  logic [9:0]  food_y,
    snake_if.slave      rd,
    output logic [9:0]  head_x,
    output logic [9:0]  head_y,
    output logic [LW:0] length,
    output logic [7:0]  score,
    output logic        food_eaten,
    output logic        running,
    output logic        game_over
);

    localparam logic [LW:0] INIT_LEN_C = INIT_LEN[LW:0];
    localparam logic [LW:0] MAX_LEN_C  = MAX_LEN[LW:0];

    function automatic logic [7:0] sat_inc8(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t  state, state_nx;
    dir_t    dir, pending, nh_dir;
    coord_t  seg_x_r [MAX_LEN];
    coord_t  seg_y_r [MAX_LEN];
    coord_t  nh_x_q, nh_y_q;
    logic    eat_q;

    scoord_t nh_xs, nh_ys, xmin_s, ymin_s;
    logic    wall_hit, self_hit, eat;
    int      self_lim;
    logic    tick;
    logic [3:0] btn_vec;
    logic    btn_take;
    dir_t    btn_dir;
    coord_t  init_hx, init_hy;

    snake_tick_gen #(
        .MOVE_FRAMES(MOVE_FRAMES)
    ) u_tick (
        .pclk     (pclk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .en       (state == ST_RUN),
        .clr      (state == ST_INIT),
        .tick     (tick)
    );

    assign head_x       = seg_x_r[0];
    assign head_y       = seg_y_r[0];
    assign rd.seg_x     = seg_x_r[rd.seg_idx];
    assign rd.seg_y     = seg_y_r[rd.seg_idx];
    assign rd.seg_valid = ({1'b0, rd.seg_idx} < length);

    assign init_hx = field_x_min + coord_t'(FIELD_W / 2);
    assign init_hy = field_y_min + coord_t'(FIELD_H / 2);

    // Next-head evaluation; one bit of headroom so stepping left/up off x=0/y=0
    // goes negative and reads as a wall hit rather than wrapping.
    always_comb begin
        xmin_s   = scoord_t'({1'b0, field_x_min});
        ymin_s   = scoord_t'({1'b0, field_y_min});
        nh_xs    = scoord_t'({1'b0, seg_x_r[0]}) + delta_x(pending);
        nh_ys    = scoord_t'({1'b0, seg_y_r[0]}) + delta_y(pending);
        wall_hit = (nh_xs < xmin_s) || (nh_xs >= xmin_s + scoord_t'(FIELD_W)) ||
                   (nh_ys < ymin_s) || (nh_ys >= ymin_s + scoord_t'(FIELD_H));
        eat      = (nh_xs == scoord_t'({1'b0, food_x})) &&
                   (nh_ys == scoord_t'({1'b0, food_y}));
        // The tail vacates its cell on a normal move but stays put when growing.
        self_lim = int'(length) - 1 + (eat ? 1 : 0);
        self_hit = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if ((k < self_lim) && (seg_x_r[k] == nh_xs[9:0]) && (seg_y_r[k] == nh_ys[9:0])) begin
                self_hit = 1'b1;
            end
        end
    end

    always_comb begin
        btn_vec = {btn_left, btn_down, btn_right, btn_up};
        btn_dir = DIR_UP;
        case (btn_vec)
            4'b0010: btn_dir = DIR_RIGHT;
            4'b0100: btn_dir = DIR_DOWN;
            4'b1000: btn_dir = DIR_LEFT;
            default: btn_dir = DIR_UP;
        endcase
        btn_take = $onehot(btn_vec) && !is_opposite(btn_dir, dir) &&
                   ((state == ST_RUN) || (state == ST_CHECK) || (state == ST_MOVE));
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_INIT;
            ST_INIT:  state_nx = ST_RUN;
            ST_RUN:   if (tick) state_nx = ST_CHECK;
            ST_CHECK: state_nx = (wall_hit || self_hit) ? ST_OVER : ST_MOVE;
            ST_MOVE:  state_nx = ST_RUN;
            ST_OVER:  if (start) state_nx = ST_INIT;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // running/game_over are registered from the state, so they follow it by one
    // edge: running rises at the edge leaving INIT, game_over with the MOVE slot.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x_r[k] <= '0;
                seg_y_r[k] <= '0;
            end
            dir        <= DIR_RIGHT;
            pending    <= DIR_RIGHT;
            nh_dir     <= DIR_RIGHT;
            nh_x_q     <= '0;
            nh_y_q     <= '0;
            eat_q      <= 1'b0;
            length     <= '0;
            score      <= '0;
            food_eaten <= 1'b0;
            running    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            food_eaten <= 1'b0;
            running    <= (state != ST_IDLE) && (state != ST_OVER);
            game_over  <= (state == ST_OVER);
            if (btn_take) begin
                pending <= btn_dir;
            end
            case (state)
                ST_INIT: begin
                    for (int k = 0; k < MAX_LEN; k++) begin
                        seg_x_r[k] <= init_hx - coord_t'(k);
                        seg_y_r[k] <= init_hy;
                    end
                    dir     <= DIR_RIGHT;
                    pending <= DIR_RIGHT;
                    length  <= INIT_LEN_C;
                    score   <= '0;
                end
                ST_CHECK: begin
                    nh_x_q <= nh_xs[9:0];
                    nh_y_q <= nh_ys[9:0];
                    eat_q  <= eat;
                    nh_dir <= pending;
                end
                ST_MOVE: begin
                    for (int k = MAX_LEN - 1; k > 0; k--) begin
                        seg_x_r[k] <= seg_x_r[k-1];
                        seg_y_r[k] <= seg_y_r[k-1];
                    end
                    seg_x_r[0] <= nh_x_q;
                    seg_y_r[0] <= nh_y_q;
                    dir        <= nh_dir;
                    if (eat_q) begin
                        if (length != MAX_LEN_C) begin
                            length <= length + 1'b1;
                        end
                        score      <= sat_inc8(score);
                        food_eaten <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
